// File: rtl/decode_regfile_pipe.sv
// Y86-64 decode stage: specifier decode (including implicit %rsp), a register
// file with two writeback ports and write-first bypass, and a D->E pipeline
// register behind a valid/ready handshake with flush.
module decode_regfile_pipe #(
  parameter int              DATA_W   = 64,
  parameter int              NUM_REGS = 15,
  parameter logic [3:0]      RSP_IDX  = 4'd4,
  parameter logic [DATA_W-1:0] REG_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              flush,
  input  logic              wb_e_en,
  input  logic [3:0]        wb_e_dst,
  input  logic [DATA_W-1:0] wb_e_val,
  input  logic              wb_m_en,
  input  logic [3:0]        wb_m_dst,
  input  logic [DATA_W-1:0] wb_m_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_valA,
  output logic [DATA_W-1:0] out_valB,
  output logic [3:0]        out_srcA,
  output logic [3:0]        out_srcB,
  output logic [3:0]        out_dstE,
  output logic [3:0]        out_dstM,
  output logic              out_ins_err
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [4:0] NREGS = 5'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [3:0]        srcA_d, srcB_d, dstE_d, dstM_d;
  logic              err_d;
  logic [DATA_W-1:0] valA_d, valB_d;
  logic              load;

  logic              valid_q, err_q;
  logic [3:0]        icode_q, srcA_q, srcB_q, dstE_q, dstM_q;
  logic [DATA_W-1:0] valA_q, valB_q;

  // Read one port: out-of-range/RNONE gives 0, otherwise M beats E beats array.
  function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] src,
                                                input logic [DATA_W-1:0] arr_v);
    logic [DATA_W-1:0] v;
    v = '0;
    if ({1'b0, src} < NREGS) begin
      if (wb_m_en && wb_m_dst == src)      v = wb_m_val;
      else if (wb_e_en && wb_e_dst == src) v = wb_e_val;
      else                                 v = arr_v;
    end
    return v;
  endfunction

  // Derive source/destination specifiers from the instruction code.
  always_comb begin
    srcA_d = RNONE;
    srcB_d = RNONE;
    dstE_d = RNONE;
    dstM_d = RNONE;
    err_d  = 1'b0;
    case (icode)
      4'h0, 4'h1, 4'h7: ;
      4'h2: begin srcA_d = rA; dstE_d = rB; end
      4'h3: dstE_d = rB;
      4'h4: begin srcA_d = rA; srcB_d = rB; end
      4'h5: begin srcB_d = rB; dstM_d = rA; end
      4'h6: begin srcA_d = rA; srcB_d = rB; dstE_d = rB; end
      4'h8: begin srcB_d = RSP_IDX; dstE_d = RSP_IDX; end
      4'h9: begin srcA_d = RSP_IDX; srcB_d = RSP_IDX; dstE_d = RSP_IDX; end
      4'hA: begin srcA_d = rA; srcB_d = RSP_IDX; dstE_d = RSP_IDX; end
      4'hB: begin srcA_d = RSP_IDX; srcB_d = RSP_IDX; dstE_d = RSP_IDX; dstM_d = rA; end
      default: err_d = 1'b1;
    endcase
  end

  // Operand reads with writeback bypass.
  always_comb begin
    valA_d = rd_port(srcA_d, regs_q[srcA_d]);
    valB_d = rd_port(srcB_d, regs_q[srcB_d]);
  end

  // Handshake: flush blocks acceptance for the cycle.
  always_comb begin
    in_ready = (!valid_q || out_ready) && !flush;
    load     = in_valid && in_ready;
  end

  // Register file: E port first, then M so M wins on a shared destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_e_en && wb_e_dst == 4'(i)) regs_q[i] <= wb_e_val;
        if (wb_m_en && wb_m_dst == 4'(i)) regs_q[i] <= wb_m_val;
      end
    end
  end

  // D->E pipeline register: flush dominates load, load dominates drain/stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      icode_q <= 4'h0;
      valA_q  <= '0;
      valB_q  <= '0;
      srcA_q  <= RNONE;
      srcB_q  <= RNONE;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
      err_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      srcA_q  <= RNONE;
      srcB_q  <= RNONE;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
    end else if (load) begin
      valid_q <= 1'b1;
      icode_q <= icode;
      valA_q  <= valA_d;
      valB_q  <= valB_d;
      srcA_q  <= srcA_d;
      srcB_q  <= srcB_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      err_q   <= err_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_icode   = icode_q;
  assign out_valA    = valA_q;
  assign out_valB    = valB_q;
  assign out_srcA    = srcA_q;
  assign out_srcB    = srcB_q;
  assign out_dstE    = dstE_q;
  assign out_dstM    = dstM_q;
  assign out_ins_err = err_q;

endmodule
